// File: rtl/ir_beacon_pkg.sv
// IR beacon shared definitions: state codes, mode codes, half-period math.
// Mode codes are shared with the rover receiver side.
package ir_beacon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_GAP  = 2'd2,
      ST_LOCK = 2'd3
   } state_t;

   localparam logic [3:0] MODE_F = 4'b0011;
   localparam logic [3:0] MODE_C = 4'b1100;

   function automatic int unsigned half_period(
      input int unsigned clk_hz,
      input int unsigned f_hz
   );
      return clk_hz / (2 * f_hz);
   endfunction

endpackage

// File: rtl/ir_beacon_if.sv
// IR beacon control/status bundle.
// master: drives en/mode_sel/hit_in; slave (beacon) drives LED and status.
interface ir_beacon_if;

   logic       en;
   logic       mode_sel;
   logic       hit_in;
   logic       led_out;
   logic [1:0] state_o;
   logic [3:0] mode_o;
   logic [3:0] hit_count;

   modport master (
      output en, mode_sel, hit_in,
      input  led_out, state_o, mode_o, hit_count
   );

   modport slave (
      input  en, mode_sel, hit_in,
      output led_out, state_o, mode_o, hit_count
   );

endinterface

// File: rtl/ir_beacon_debounce.sv
// Impact switch conditioner: 2-flop sync, ms-sampled debounce, one-shot.
// Ports: clk, rst, ms_tick (sample strobe), raw_in (async), evt_out (pulse).
module ir_beacon_debounce #(
   parameter int unsigned DEB_MS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic ms_tick,
   input  logic raw_in,
   output logic evt_out
);

   localparam int unsigned CW = $clog2(DEB_MS + 1);
   localparam logic [CW-1:0] LAST = CW'(DEB_MS - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_armed;
   logic          r_evt;
   logic [CW-1:0] r_cnt;
   logic          w_accept;

   // r_cnt holds the number of earlier consecutive high samples
   assign w_accept = ms_tick && r_sync2 && r_armed && (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_armed <= 1'b1;
         r_evt   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= raw_in;
         r_sync2 <= r_sync1;
         r_evt   <= w_accept;
         if (ms_tick) begin
            if (!r_sync2) begin
               r_cnt   <= '0;
               r_armed <= 1'b1;
            end else if (w_accept) begin
               r_armed <= 1'b0;
            end else if (r_cnt != LAST) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign evt_out = r_evt;

endmodule

// File: rtl/ir_beacon_tx.sv
// IR beacon transmitter: ms tick, tone generator, on/gap/lock FSM.
// Ports: clk, rst (sync, active-high), bus (ir_beacon_if.slave).
module ir_beacon_tx
   import ir_beacon_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100000000,
   parameter int unsigned F_HZ    = 500,
   parameter int unsigned C_HZ    = 1500,
   parameter int unsigned ON_MS   = 2000,
   parameter int unsigned GAP_MS  = 500,
   parameter int unsigned LOCK_MS = 3000,
   parameter int unsigned DEB_MS  = 4
) (
   input  logic        clk,
   input  logic        rst,
   ir_beacon_if.slave  bus
);

   localparam int unsigned TICK_DIV = CLK_HZ / 1000;
   localparam int unsigned TW = $clog2(TICK_DIV + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   localparam int unsigned HALF_F = half_period(CLK_HZ, F_HZ);
   localparam int unsigned HALF_C = half_period(CLK_HZ, C_HZ);
   localparam int unsigned HALF_M = (HALF_F > HALF_C) ? HALF_F : HALF_C;
   localparam int unsigned PW = $clog2(HALF_M + 1);
   localparam logic [PW-1:0] LAST_F = PW'(HALF_F - 1);
   localparam logic [PW-1:0] LAST_C = PW'(HALF_C - 1);

   localparam int unsigned MS_A = (ON_MS > GAP_MS) ? ON_MS : GAP_MS;
   localparam int unsigned MS_M = (MS_A > LOCK_MS) ? MS_A : LOCK_MS;
   localparam int unsigned MW = $clog2(MS_M + 1);
   localparam logic [MW-1:0] ON_LAST   = MW'(ON_MS - 1);
   localparam logic [MW-1:0] GAP_LAST  = MW'(GAP_MS - 1);
   localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_MS - 1);

   logic [TW-1:0] r_tick_cnt;
   logic          w_ms_tick;
   logic          w_hit_evt;

   state_t        r_state;
   state_t        w_state_n;
   logic          r_mode;
   logic          w_mode_n;
   logic [PW-1:0] r_phase;
   logic [PW-1:0] w_phase_n;
   logic [PW-1:0] w_half_last;
   logic [MW-1:0] r_ms_cnt;
   logic [MW-1:0] w_ms_n;
   logic          r_led;
   logic          w_led_n;
   logic [3:0]    r_hits;
   logic [3:0]    w_hits_n;
   logic [3:0]    w_hits_inc;

   // free-running ms strobe, only rst clears it
   assign w_ms_tick = (r_tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (rst || w_ms_tick) r_tick_cnt <= '0;
      else                  r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   ir_beacon_debounce #(
      .DEB_MS (DEB_MS)
   ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .ms_tick (w_ms_tick),
      .raw_in  (bus.hit_in),
      .evt_out (w_hit_evt)
   );

   assign w_half_last = r_mode ? LAST_C : LAST_F;
   assign w_hits_inc  = (r_hits == 4'hF) ? r_hits : r_hits + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_mode   <= 1'b0;
         r_phase  <= '0;
         r_ms_cnt <= '0;
         r_led    <= 1'b0;
         r_hits   <= 4'h0;
      end else begin
         r_state  <= w_state_n;
         r_mode   <= w_mode_n;
         r_phase  <= w_phase_n;
         r_ms_cnt <= w_ms_n;
         r_led    <= w_led_n;
         r_hits   <= w_hits_n;
      end
   end

   // priority inside ON/GAP: en low, then hit, then timer
   always_comb begin
      w_state_n = r_state;
      w_mode_n  = r_mode;
      w_phase_n = r_phase;
      w_led_n   = r_led;
      w_hits_n  = r_hits;
      w_ms_n    = w_ms_tick ? r_ms_cnt + 1'b1 : r_ms_cnt;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.en) w_state_n = ST_ON;
         end
         ST_ON: begin
            if (!bus.en) begin
               w_state_n = ST_IDLE;
            end else if (w_hit_evt) begin
               w_state_n = ST_LOCK;
               w_hits_n  = w_hits_inc;
            end else if (w_ms_tick && r_ms_cnt == ON_LAST) begin
               w_state_n = ST_GAP;
            end else if (r_phase == w_half_last) begin
               w_phase_n = '0;
               w_led_n   = ~r_led;
            end else begin
               w_phase_n = r_phase + 1'b1;
            end
         end
         ST_GAP: begin
            if (!bus.en) begin
               w_state_n = ST_IDLE;
            end else if (w_hit_evt) begin
               w_state_n = ST_LOCK;
               w_hits_n  = w_hits_inc;
            end else if (w_ms_tick && r_ms_cnt == GAP_LAST) begin
               w_state_n = ST_ON;
            end
         end
         ST_LOCK: begin
            if (w_ms_tick && r_ms_cnt == LOCK_LAST)
               w_state_n = bus.en ? ST_ON : ST_IDLE;
         end
         default: w_state_n = ST_IDLE;
      endcase
      // every transition restarts timing; ON entry relatches the mode
      if (w_state_n != r_state) begin
         w_ms_n    = '0;
         w_phase_n = '0;
         w_led_n   = (w_state_n == ST_ON);
         if (w_state_n == ST_ON) w_mode_n = bus.mode_sel;
      end
   end

   assign bus.led_out   = r_led;
   assign bus.state_o   = r_state;
   assign bus.mode_o    = (r_state != ST_ON) ? 4'h0 :
                          (r_mode ? MODE_C : MODE_F);
   assign bus.hit_count = r_hits;

endmodule

// File: tb/tb_ir_beacon_tx.sv
// Self-checking bench for ir_beacon_tx, run with a scaled clock
// (10 cycles per ms) so full windows fit in a short simulation.
module tb_ir_beacon_tx;
   import ir_beacon_pkg::*;

   localparam int T    = 10;
   localparam int ONM  = 20;
   localparam int GAPM = 5;
   localparam int LCKM = 30;
   localparam int BIG  = 100000;

   typedef struct {
      logic [1:0] st;
      logic [3:0] mode;
      logic       led;
      int         hits;
      int         lo;
      int         hi;
   } exp_t;

   typedef struct {
      logic       sel;
      logic       flip;
      int         half;
      logic [3:0] m1;
      logic [3:0] m2;
   } tone_vec_t;

   logic clk;
   logic rst;
   ir_beacon_if u_if ();

   ir_beacon_tx #(
      .CLK_HZ  (10000),
      .F_HZ    (500),
      .C_HZ    (1500),
      .ON_MS   (ONM),
      .GAP_MS  (GAPM),
      .LOCK_MS (LCKM),
      .DEB_MS  (4)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   int n_chk = 0;
   int n_fail = 0;
   int dark_viol = 0;
   exp_t sb_q[$];
   bit mon_en = 0;
   logic [1:0] mon_last = 2'd0;
   int dwell = 1;
   tone_vec_t tv[3];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int lo_ms(input int n);
      return T * (n - 1) + 1;
   endfunction

   function automatic int hi_ms(input int n);
      return T * n;
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_rng(input string nm, input int act,
                            input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic push(input logic [1:0] st, input logic [3:0] m,
                       input logic l, input int h,
                       input int lo, input int hi);
      exp_t e;
      e.st = st; e.mode = m; e.led = l;
      e.hits = h; e.lo = lo; e.hi = hi;
      sb_q.push_back(e);
   endtask

   task automatic wait_sb(input int maxc);
      int c;
      c = 0;
      while (sb_q.size() != 0 && c < maxc) begin
         @(negedge clk);
         c++;
      end
      check("sb_drain", sb_q.size(), 0);
      sb_q.delete();
   endtask

   task automatic wait_state(input logic [1:0] st, input int maxc);
      int c;
      c = 0;
      while (u_if.state_o !== st && c < maxc) begin
         @(negedge clk);
         c++;
      end
      check("wait_state", u_if.state_o, st);
   endtask

   task automatic do_reset();
      mon_en = 0;
      rst = 1'b1;
      u_if.en = 1'b0;
      u_if.hit_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mon_last = u_if.state_o;
      dwell = 1;
      mon_en = 1;
   endtask

   // scoreboard consumer: one expected record per state change
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (mon_en) begin
            if (u_if.state_o != ST_ON &&
                (u_if.led_out || u_if.mode_o != 4'h0))
               dark_viol++;
            if (u_if.state_o != mon_last) begin
               if (sb_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL sb_unexpected: state %0d from %0d",
                           u_if.state_o, mon_last);
               end else begin
                  e = sb_q.pop_front();
                  check("sb_state", u_if.state_o, e.st);
                  check("sb_mode", u_if.mode_o, e.mode);
                  check("sb_led", u_if.led_out, e.led);
                  check("sb_hits", u_if.hit_count, e.hits);
                  check_rng("sb_dwell", dwell, e.lo, e.hi);
               end
               mon_last = u_if.state_o;
               dwell = 1;
            end else begin
               dwell++;
            end
         end
      end
   end

   initial begin
      int cnt;
      logic prev;

      tv[0] = '{sel: 1'b0, flip: 1'b0, half: 10, m1: MODE_F, m2: MODE_F};
      tv[1] = '{sel: 1'b1, flip: 1'b0, half: 3,  m1: MODE_C, m2: MODE_C};
      tv[2] = '{sel: 1'b1, flip: 1'b1, half: 3,  m1: MODE_C, m2: MODE_F};

      rst = 1'b1;
      u_if.en = 1'b0;
      u_if.mode_sel = 1'b0;
      u_if.hit_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_led", u_if.led_out, 0);
      check("rst_state", u_if.state_o, ST_IDLE);
      check("rst_mode", u_if.mode_o, 0);
      check("rst_hits", u_if.hit_count, 0);
      rst = 1'b0;
      repeat (T + 2) @(negedge clk);
      check("idle_state", u_if.state_o, ST_IDLE);
      check("idle_led", u_if.led_out, 0);

      // tone rate table, then gap and re-entry mode
      for (int i = 0; i < 3; i++) begin
         do_reset();
         u_if.mode_sel = tv[i].sel;
         push(ST_ON, tv[i].m1, 1'b1, 0, 0, 5);
         u_if.en = 1'b1;
         wait_state(ST_ON, 5);
         prev = u_if.led_out;
         for (int k = 0; k < 4; k++) begin
            cnt = 0;
            do begin
               @(negedge clk);
               cnt++;
            end while (u_if.led_out == prev && cnt < 50);
            prev = u_if.led_out;
            check("tone_half", cnt, tv[i].half);
            if (tv[i].flip && k == 0) u_if.mode_sel = ~tv[i].sel;
         end
         push(ST_GAP, 4'h0, 1'b0, 0, lo_ms(ONM), hi_ms(ONM));
         push(ST_ON, tv[i].m2, 1'b1, 0, lo_ms(GAPM), hi_ms(GAPM));
         wait_sb(T * (ONM + GAPM) + 20);
      end

      // short pulse rejected, long pulse accepted, hit in LOCK ignored
      do_reset();
      u_if.mode_sel = 1'b0;
      push(ST_ON, MODE_F, 1'b1, 0, 0, 5);
      u_if.en = 1'b1;
      wait_sb(5);
      u_if.hit_in = 1'b1;
      repeat (2 * T) @(negedge clk);
      u_if.hit_in = 1'b0;
      repeat (3 * T) @(negedge clk);
      check("short_hit_state", u_if.state_o, ST_ON);
      check("short_hit_count", u_if.hit_count, 0);
      push(ST_LOCK, 4'h0, 1'b0, 1, 1, BIG);
      u_if.hit_in = 1'b1;
      cnt = 0;
      while (u_if.state_o !== ST_LOCK && cnt < 80) begin
         @(negedge clk);
         cnt++;
      end
      check_rng("deb_latency", cnt, 34, 43);
      repeat (15) @(negedge clk);
      u_if.hit_in = 1'b0;
      repeat (2 * T) @(negedge clk);
      u_if.hit_in = 1'b1;
      repeat (5 * T) @(negedge clk);
      u_if.hit_in = 1'b0;
      check("lock_hit_ignored", u_if.hit_count, 1);
      push(ST_ON, MODE_F, 1'b1, 1, lo_ms(LCKM), hi_ms(LCKM));
      wait_sb(T * LCKM + 20);

      // en drop on the same cycle as a hit event
      push(ST_IDLE, 4'h0, 1'b0, 1, 1, BIG);
      u_if.hit_in = 1'b1;
      cnt = 0;
      while (u_dut.w_hit_evt !== 1'b1 && cnt < 80) begin
         @(negedge clk);
         cnt++;
      end
      check("evt_seen", u_dut.w_hit_evt, 1);
      u_if.en = 1'b0;
      wait_sb(5);
      check("en_beats_hit", u_if.hit_count, 1);
      u_if.hit_in = 1'b0;
      repeat (2 * T) @(negedge clk);
      push(ST_ON, MODE_F, 1'b1, 1, 1, BIG);
      u_if.en = 1'b1;
      wait_sb(5);

      // saturation of the hit counter
      for (int h = 2; h <= 16; h++) begin
         push(ST_LOCK, 4'h0, 1'b0, (h > 15) ? 15 : h, 1, BIG);
         u_if.hit_in = 1'b1;
         wait_state(ST_LOCK, 60);
         repeat (10) @(negedge clk);
         u_if.hit_in = 1'b0;
         push(ST_ON, MODE_F, 1'b1, (h > 15) ? 15 : h,
              lo_ms(LCKM), hi_ms(LCKM));
         wait_sb(T * LCKM + 20);
      end
      check("hit_sat", u_if.hit_count, 15);

      // en low during LOCK: lockout runs to completion, then IDLE
      push(ST_LOCK, 4'h0, 1'b0, 15, 1, BIG);
      u_if.hit_in = 1'b1;
      wait_state(ST_LOCK, 60);
      repeat (10) @(negedge clk);
      u_if.hit_in = 1'b0;
      u_if.en = 1'b0;
      push(ST_IDLE, 4'h0, 1'b0, 15, lo_ms(LCKM), hi_ms(LCKM));
      wait_sb(T * LCKM + 20);

      // reset in the middle of ON
      push(ST_ON, MODE_F, 1'b1, 15, 1, BIG);
      u_if.en = 1'b1;
      wait_sb(5);
      check("pre_rst_led", u_if.led_out, 1);
      mon_en = 0;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_led", u_if.led_out, 0);
      check("mid_rst_state", u_if.state_o, ST_IDLE);
      check("mid_rst_mode", u_if.mode_o, 0);
      check("mid_rst_hits", u_if.hit_count, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_on", u_if.state_o, ST_ON);

      check("dark_violations", dark_viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
